// File: rtl/present_key_schedule.sv
// PRESENT key-schedule engine: streams ROUNDS+1 round keys for an 80/128-bit user key,
// in forward (encrypt) or reverse (decrypt) order, one key per valid/ready handshake.
module present_key_schedule #(
  parameter int unsigned KEY_WIDTH = 80,
  parameter int unsigned ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 decrypt_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic [63:0]          rk_o,
  output logic [5:0]           rk_index_o,
  output logic                 rk_valid_o,
  input  logic                 rk_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned KW     = KEY_WIDTH;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned XOR_LO = (KW == 128) ? 62 : 15;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS + 1);

  if (!((KEY_WIDTH == 80) || (KEY_WIDTH == 128))) begin : g_bad_key_width
    $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
  end
  if ((ROUNDS < 1) || (ROUNDS > 31)) begin : g_bad_rounds
    $error("present_key_schedule: ROUNDS must be in 1..31");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRECOMP = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t             r_state;
  logic [KW-1:0]      r_key;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_dec;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [KW-1:0]      w_key_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_dec_nxt;
  logic               w_done_nxt;
  logic               w_xfer;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Rotate left 61, S-box the top nibble(s), fold the round counter in.
  function automatic logic [KW-1:0] fwd_update(input logic [KW-1:0] k, input logic [CNT_W-1:0] c);
    logic [KW-1:0] t;
    t = {k[KW-62:0], k[KW-1:KW-61]};
    t[KW-1 -: 4] = sbox(t[KW-1 -: 4]);
    if (KW == 128) t[KW-5 -: 4] = sbox(t[KW-5 -: 4]);
    t[XOR_LO +: 5] = t[XOR_LO +: 5] ^ c;
    return t;
  endfunction

  // Exact inverse of fwd_update for the same counter value.
  function automatic logic [KW-1:0] inv_update(input logic [KW-1:0] k, input logic [CNT_W-1:0] c);
    logic [KW-1:0] t;
    t = k;
    t[XOR_LO +: 5] = t[XOR_LO +: 5] ^ c;
    t[KW-1 -: 4] = inv_sbox(t[KW-1 -: 4]);
    if (KW == 128) t[KW-5 -: 4] = inv_sbox(t[KW-5 -: 4]);
    return {t[60:0], t[KW-1:61]};
  endfunction

  assign w_xfer = r_valid & rk_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_dec_nxt   = r_dec;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_key_nxt = key_i;
          w_cnt_nxt = CNT_W'(1);
          w_dec_nxt = decrypt_i;
          if (decrypt_i) begin
            w_state_nxt = S_PRECOMP;
          end else begin
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = S_EMIT;
          end
        end
      end
      S_PRECOMP: begin
        // Walk forward to the last round key before streaming it back down.
        w_key_nxt = fwd_update(r_key, r_cnt);
        if (r_cnt == LAST_CNT) begin
          w_idx_nxt   = LAST_IDX;
          w_state_nxt = S_EMIT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (w_xfer) begin
          if (r_dec) begin
            if (r_idx == IDX_W'(1)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_key_nxt = inv_update(r_key, r_cnt);
              w_idx_nxt = r_idx - IDX_W'(1);
              if (r_cnt != CNT_W'(1)) w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end else begin
            if (r_idx == LAST_IDX) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_key_nxt = fwd_update(r_key, r_cnt);
              w_idx_nxt = r_idx + IDX_W'(1);
              if (r_cnt != LAST_CNT) w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dec   <= w_dec_nxt;
      r_valid <= (w_state_nxt == S_EMIT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign rk_o       = r_key[KW-1 -: 64];
  assign rk_index_o = r_idx;
  assign rk_valid_o = r_valid;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule: three instances (80/31, 128/31, 80/1)
// checked against an arithmetic model of the PRESENT key schedule.
module tb_present_key_schedule;

  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start [NDUT];
  logic         dec   [NDUT];
  logic         rdy   [NDUT];
  logic [127:0] keyi  [NDUT];
  logic [63:0]  rk    [NDUT];
  logic [5:0]   idx   [NDUT];
  logic         valid [NDUT];
  logic         busy  [NDUT];
  logic         done  [NDUT];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got   [64];
  logic [63:0] saved [64];
  int          ngot;
  int          nsaved;

  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_key_schedule #(.KEY_WIDTH(80), .ROUNDS(31)) u_k80 (
    .clk(clk), .rst(rst), .start_i(start[0]), .decrypt_i(dec[0]), .key_i(keyi[0][79:0]),
    .rk_o(rk[0]), .rk_index_o(idx[0]), .rk_valid_o(valid[0]), .rk_ready_i(rdy[0]),
    .busy_o(busy[0]), .done_o(done[0]));

  present_key_schedule #(.KEY_WIDTH(128), .ROUNDS(31)) u_k128 (
    .clk(clk), .rst(rst), .start_i(start[1]), .decrypt_i(dec[1]), .key_i(keyi[1]),
    .rk_o(rk[1]), .rk_index_o(idx[1]), .rk_valid_o(valid[1]), .rk_ready_i(rdy[1]),
    .busy_o(busy[1]), .done_o(done[1]));

  present_key_schedule #(.KEY_WIDTH(80), .ROUNDS(1)) u_r1 (
    .clk(clk), .rst(rst), .start_i(start[2]), .decrypt_i(dec[2]), .key_i(keyi[2][79:0]),
    .rk_o(rk[2]), .rk_index_o(idx[2]), .rk_valid_o(valid[2]), .rk_ready_i(rdy[2]),
    .busy_o(busy[2]), .done_o(done[2]));

  function automatic int kw_of(input int d);
    return (d == 1) ? 128 : 80;
  endfunction

  function automatic int rounds_of(input int d);
    return (d == 2) ? 1 : 31;
  endfunction

  function automatic logic [127:0] rand_key(input int d);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (kw_of(d) == 80) k = k & ((128'd1 << 80) - 128'd1);
    return k;
  endfunction

  // Reference: list K1..K(nr+1) from the key-update rules, reversed for decrypt.
  function automatic void build_exp(input int kw, input int nr, input logic [127:0] key, input logic dir);
    logic [127:0] k;
    logic [127:0] mask;
    logic [3:0]   v;
    logic [63:0]  ks[$];
    int           sh;
    mask = (kw == 128) ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
    k = key & mask;
    for (int j = 1; j <= nr + 1; j++) begin
      ks.push_back(64'(k >> (kw - 64)));
      if (j <= nr) begin
        k = ((k << 61) | (k >> (kw - 61))) & mask;
        for (int nb = 0; nb < ((kw == 128) ? 2 : 1); nb++) begin
          sh = kw - 4 - 4 * nb;
          v  = 4'(k >> sh);
          k  = (k & ~(128'hF << sh)) | (128'(SB[v]) << sh);
        end
        k = k ^ (128'(j) << ((kw == 128) ? 62 : 15));
      end
    end
    exp_q.delete();
    for (int j = 0; j < ks.size(); j++) exp_q.push_back(dir ? ks[ks.size() - 1 - j] : ks[j]);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Runs one schedule on DUT d starting at the current negedge; ends at the done-cycle negedge.
  task automatic run(input int d, input logic [127:0] key, input logic dir, input int stall_pct,
                     input int glitch_at, input int abort_idx);
    int          nr, n, p, lat_exp;
    bit          first, prev_stall, finished;
    logic [63:0] prev_rk;
    logic [5:0]  prev_idx, eidx;
    nr = rounds_of(d);
    build_exp(kw_of(d), nr, key, dir);
    n = exp_q.size();
    lat_exp = dir ? nr + 1 : 1;
    p = 0; first = 1'b1; prev_stall = 1'b0; finished = 1'b0;
    prev_rk = '0; prev_idx = '0;
    start[d] = 1'b1; keyi[d] = key; dec[d] = dir; rdy[d] = 1'b0;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == glitch_at) begin
        start[d] = 1'b1; keyi[d] = {$urandom, $urandom, $urandom, $urandom}; dec[d] = ~dir;
      end else begin
        start[d] = 1'b0;
      end
      if (p == n) begin
        chk("done_cycle", 128'({done[d], busy[d], valid[d]}), 128'(3'b100));
        finished = 1'b1;
      end else begin
        chk("no_early_done", 128'(done[d]), 128'(0));
        chk("busy", 128'(busy[d]), 128'(1));
        if (valid[d]) begin
          if (first) chk("first_latency", 128'(cyc), 128'(lat_exp));
          first = 1'b0;
          if (prev_stall) chk("stall_hold", 128'({rk[d], idx[d]}), 128'({prev_rk, prev_idx}));
          eidx = dir ? 6'(nr + 1 - p) : 6'(p + 1);
          chk("rk", 128'(rk[d]), 128'(exp_q[p]));
          chk("rk_index", 128'(idx[d]), 128'(eidx));
          if (abort_idx != 0 && idx[d] == 6'(abort_idx)) begin
            rst = 1'b1;
            #1;
            chk("reset_abort", 128'({rk[d], idx[d], valid[d], busy[d], done[d]}), 128'(0));
            rdy[d] = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
          end
          rdy[d] = (int'($urandom_range(99)) >= stall_pct);
          prev_stall = !rdy[d]; prev_rk = rk[d]; prev_idx = idx[d];
          if (rdy[d]) begin
            got[p] = rk[d];
            p++;
          end
        end else begin
          if (!first) chk("valid_gap", 128'(valid[d]), 128'(1));
          rdy[d] = 1'($urandom_range(1));
        end
      end
    end
    ngot = p;
    chk("schedule_finished", 128'(finished), 128'(1));
    rdy[d] = 1'b0;
  endtask

  typedef struct {
    int           d;
    logic [127:0] key;
    logic [63:0]  k1;
    logic [63:0]  k2;
    int           n;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{0, 128'h0, 64'h0, 64'hC000_0000_0000_0000, 32};
    tbl[1] = '{1, 128'h0, 64'h0, 64'hCC00_0000_0000_0000, 32};
    tbl[2] = '{0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2FFF_FFFF_FFFF_FFFF, 32};
    tbl[3] = '{1, {128{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22FF_FFFF_FFFF_FFFF, 32};
    tbl[4] = '{2, 128'h0, 64'h0, 64'hC000_0000_0000_0000, 2};

    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0; dec[d] = 1'b0; rdy[d] = 1'b0; keyi[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      chk("reset_state", 128'({rk[d], idx[d], valid[d], busy[d], done[d]}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Known-answer forward schedules.
    for (int t = 0; t < 5; t++) begin
      run(tbl[t].d, tbl[t].key, 1'b0, 0, 0, 0);
      chk("kat_k1", 128'(got[0]), 128'(tbl[t].k1));
      chk("kat_k2", 128'(got[1]), 128'(tbl[t].k2));
      chk("kat_count", 128'(ngot), 128'(tbl[t].n));
      repeat (2) @(negedge clk);
    end

    // Reverse order must be the forward order reversed; the decrypt run starts in the done cycle.
    for (int i = 0; i < 5; i++) begin
      int d;
      logic [127:0] k;
      d = (i == 4) ? 2 : (i % 2);
      k = rand_key(d);
      run(d, k, 1'b0, 0, 0, 0);
      nsaved = ngot;
      for (int j = 0; j < ngot; j++) saved[j] = got[j];
      run(d, k, 1'b1, 0, 0, 0);
      chk("rev_count", 128'(ngot), 128'(nsaved));
      for (int j = 0; j < ngot; j++) chk("rev_vs_fwd", 128'(got[j]), 128'(saved[nsaved - 1 - j]));
      repeat (2) @(negedge clk);
    end

    // Random backpressure in both directions on every instance.
    for (int i = 0; i < 6; i++) begin
      run(i % 3, rand_key(i % 3), 1'(i % 2), 40, 0, 0);
      repeat (1) @(negedge clk);
    end

    // start_i pulses during PRECOMP and EMIT must be ignored.
    run(0, rand_key(0), 1'b1, 0, 5, 0);
    repeat (2) @(negedge clk);
    run(1, rand_key(1), 1'b0, 25, 7, 0);
    repeat (2) @(negedge clk);
    run(0, rand_key(0), 1'b1, 30, 40, 0);
    repeat (2) @(negedge clk);

    // Reset while streaming index 10, then a full schedule from K1.
    begin
      logic [127:0] k;
      k = rand_key(0);
      run(0, k, 1'b0, 0, 0, 10);
      run(0, k, 1'b0, 0, 0, 0);
      chk("post_reset_count", 128'(ngot), 128'(32));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/present_key_schedule.md
# present_key_schedule

Sequential PRESENT key-schedule engine that turns a user key into the full stream of 64-bit round keys, one per handshake. It supports both 80-bit and 128-bit keys and both forward (encryption) and reverse (decryption) order. It sits between the key-load interface and the round datapath of the encryption and decryption cores, and it replaces per-round instantiation of a combinational key-update stage.

## Interface
Parameters:
- KEY_WIDTH, 80: user key width; legal values are 80 and 128 only; any other value is an elaboration error.
- ROUNDS, 31: number of key updates, legal range 1..31; the engine emits ROUNDS+1 round keys.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a schedule; sampled only in IDLE.
- decrypt_i  in  1  sampled together with start_i; 0 gives keys in order K1..K(ROUNDS+1), 1 gives them in order K(ROUNDS+1)..K1.
- key_i  in  KEY_WIDTH  user key, sampled on an accepted start.
- rk_o  out  64  current round key, equal to the top 64 bits of the key register.
- rk_index_o  out  6  index of rk_o, in the range 1..ROUNDS+1.
- rk_valid_o  out  1  rk_o and rk_index_o are valid.
- rk_ready_i  in  1  consumer accepts rk_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last round key transfers.

## Operation
- Forward update at counter i, for i = 1..ROUNDS:
  - Rotate the key register left by 61.
  - Pass the top nibble (80-bit key) or the top two nibbles (128-bit key) through the PRESENT S-box.
  - XOR i into bits [19:15] (80-bit key) or bits [66:62] (128-bit key).
- Inverse update at counter i, as the exact reverse of the forward update:
  - XOR i into the same bit field.
  - Apply the inverse S-box to the same nibble(s).
  - Rotate the key register right by 61.
- Round keys: K1 is derived from key_i; K(j+1) is the forward update of K(j) with counter j.
- The round counter is 5 bits wide and never wraps; its values run 1..ROUNDS. rk_index_o is 6 bits wide.
- State machine:
  - IDLE: start_i=1 loads key_i, sets the counter to 1, and latches decrypt_i.
    - If decrypt_i=0, go to EMIT with rk_index_o=1.
    - If decrypt_i=1, go to PRECOMP.
  - PRECOMP: apply one forward update per cycle for counter 1..ROUNDS. After the update with counter ROUNDS, set the counter to ROUNDS and rk_index_o to ROUNDS+1, then go to EMIT.
  - EMIT: rk_valid_o=1. A transfer occurs when rk_valid_o and rk_ready_i are both high.
    - Forward order: each transfer applies a forward update with the counter equal to rk_index_o, then increments rk_index_o.
    - Reverse order: each transfer applies an inverse update with the counter equal to rk_index_o-1, then decrements rk_index_o.
    - A transfer of the last key (index ROUNDS+1 in forward order, index 1 in reverse order) pulses done_o and returns to IDLE with no further update.
- start_i outside IDLE is ignored. decrypt_i and key_i are don't-care except on an accepted start.
- Backpressure: while rk_valid_o=1 and rk_ready_i=0, rk_o and rk_index_o stay stable and no update occurs.

## Timing
- Reset, asynchronous: state=IDLE, key register=0, counter=0, rk_o=0, rk_index_o=0, rk_valid_o=0, busy_o=0, done_o=0. Reset asserted mid-schedule aborts the schedule immediately. The first start after reset release is accepted normally.
- Forward order: K1 is valid in the cycle after start_i.
- Reverse order: K(ROUNDS+1) is valid ROUNDS+1 cycles after start_i (ROUNDS PRECOMP cycles plus one).
- Throughput is one key per cycle with rk_ready_i held high; there are no bubbles between keys.
- done_o is registered and is high in the cycle after the final transfer. In that same cycle busy_o=0 and rk_valid_o=0.
- A start_i in the same cycle that done_o is high is accepted, so a back-to-back schedule costs no idle cycle beyond the done cycle.
- Outputs are registered; there is no combinational path from rk_ready_i to rk_o.

## Test plan
- KEY_WIDTH=80, key 0, forward, rk_ready_i=1:
  - K1=0x0000000000000000, K2=0xC000000000000000.
  - 32 keys with indices 1..32 on consecutive cycles.
  - done_o one cycle after index 32.
- KEY_WIDTH=128, key 0, forward: K1=0, K2=0xCC00000000000000, 32 keys total.
- Reverse consistency: for random keys at both widths:
  - The decrypt-mode sequence equals the forward sequence reversed.
  - First valid arrives 32 cycles after start.
  - The index sequence is 32..1.
- Backpressure: drop rk_ready_i randomly. rk_o and rk_index_o are stable while stalled, and no key is lost or duplicated.
- Boundaries:
  - start_i pulsed during PRECOMP and EMIT is ignored.
  - ROUNDS=1 emits exactly K1 and K2.
  - start_i asserted in the done_o cycle begins a new schedule.
- Reset mid-EMIT at index 10: all outputs are 0 immediately. A following start produces the full sequence from K1.
